// File: rtl/mii_tx_framer.sv
// MAC-side 10/100 MII transmit framer: preamble/SFD insertion, byte-to-nibble serialiser, inter-frame gap.
// Define MII_TX_FCS_EN to build minimum-size zero padding and CRC-32 FCS insertion.
module mii_tx_framer #(
`ifdef MII_TX_FCS_EN
  parameter int unsigned MIN_PAYLOAD      = 60,
`endif
  parameter int unsigned PREAMBLE_NIBBLES = 14,
  parameter int unsigned IFG_CYCLES       = 24
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [7:0] tx_mac_data_i,
  input  logic       tx_mac_valid_i,
  input  logic       tx_mac_last_i,
  output logic       tx_mac_ready_o,
  output logic       phy_tx_en_o,
  output logic [3:0] phy_txd_o,
  output logic       phy_tx_er_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_underrun_o
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [3:0]  NIB_PRE = 4'h5;
  localparam logic [3:0]  NIB_SFD = 4'hD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
`ifdef MII_TX_FCS_EN
    S_PAD,
    S_FCS,
`endif
    S_ERR,
    S_IFG
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic [7:0]       data_q;
  logic             last_q;
  logic             en_q;
  logic [3:0]       txd_q;
  logic             er_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             underrun_q;

`ifdef MII_TX_FCS_EN
  localparam int unsigned BCNT_W = 7;

  logic [31:0]       crc_q;
  logic [BCNT_W-1:0] bcnt_q;

  // Reflected CRC-32 (poly 0xEDB88320), one byte LSB first
  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  // A frame may start from IDLE or directly out of the last IFG cycle
  logic start_c;
  assign start_c = tx_mac_valid_i &
                   ((state_q == S_IDLE) |
                    ((state_q == S_IFG) && (cnt_q == CNT_W'(IFG_CYCLES - 1))));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      en_q       <= 1'b0;
      txd_q      <= '0;
      er_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef MII_TX_FCS_EN
      crc_q      <= '1;
      bcnt_q     <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;

      case (state_q)
        S_PRE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
            state_q <= S_SFD;
            cnt_q   <= '0;
          end
        end
        S_SFD: begin
          if (cnt_q == '0) begin
            txd_q   <= NIB_SFD;
            ready_q <= 1'b1;
            cnt_q   <= CNT_W'(1);
          end
        end
        S_DATA: begin
          if (!phase_q) begin
            txd_q   <= data_q[7:4];
            phase_q <= 1'b1;
            ready_q <= ~last_q;
`ifdef MII_TX_FCS_EN
            crc_q   <= crc_upd(crc_q, data_q);
`else
            done_q  <= last_q;
`endif
          end else if (last_q) begin
`ifdef MII_TX_FCS_EN
            phase_q <= 1'b0;
            cnt_q   <= '0;
            if (bcnt_q < BCNT_W'(MIN_PAYLOAD)) begin
              state_q <= S_PAD;
              txd_q   <= '0;
            end else begin
              state_q <= S_FCS;
              txd_q   <= ~crc_q[3:0];
              crc_q   <= crc_q >> 4;
            end
`else
            state_q <= S_IFG;
            en_q    <= 1'b0;
            txd_q   <= '0;
            cnt_q   <= '0;
`endif
          end
        end
`ifdef MII_TX_FCS_EN
        S_PAD: begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            crc_q <= crc_upd(crc_q, 8'h00);
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(MIN_PAYLOAD - 1)) begin
              state_q <= S_FCS;
              txd_q   <= ~crc_q[3:0];
              crc_q   <= crc_q >> 4;
              cnt_q   <= '0;
            end
          end
        end
        S_FCS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            state_q <= S_IFG;
            en_q    <= 1'b0;
            txd_q   <= '0;
            cnt_q   <= '0;
          end else begin
            txd_q  <= ~crc_q[3:0];
            crc_q  <= crc_q >> 4;
            done_q <= (cnt_q == CNT_W'(6));
          end
        end
`endif
        S_ERR: begin
          cnt_q      <= cnt_q + CNT_W'(1);
          underrun_q <= (cnt_q == '0);
          if (cnt_q != '0) begin
            state_q <= S_IFG;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            txd_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_IFG: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: ;
      endcase

      // Byte handshake: a ready cycle without valid aborts the frame
      if (ready_q) begin
        if (tx_mac_valid_i) begin
          state_q <= S_DATA;
          data_q  <= tx_mac_data_i;
          last_q  <= tx_mac_last_i;
          txd_q   <= tx_mac_data_i[3:0];
          phase_q <= 1'b0;
`ifdef MII_TX_FCS_EN
          if (bcnt_q < BCNT_W'(MIN_PAYLOAD)) begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
`endif
        end else begin
          state_q <= S_ERR;
          er_q    <= 1'b1;
          txd_q   <= '0;
          cnt_q   <= '0;
        end
      end

      if (start_c) begin
        state_q <= S_PRE;
        cnt_q   <= '0;
        en_q    <= 1'b1;
        txd_q   <= NIB_PRE;
        er_q    <= 1'b0;
        busy_q  <= 1'b1;
`ifdef MII_TX_FCS_EN
        crc_q   <= '1;
        bcnt_q  <= '0;
`endif
      end
    end
  end

  assign tx_mac_ready_o = ready_q;
  assign phy_tx_en_o    = en_q;
  assign phy_txd_o      = txd_q;
  assign phy_tx_er_o    = er_q;
  assign tx_busy_o      = busy_q;
  assign tx_done_o      = done_q;
  assign tx_underrun_o  = underrun_q;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Self-checking bench for mii_tx_framer: byte source, nibble scoreboard, frame length/IFG/residue checks.
module tb_mii_tx_framer;

  localparam int PRE_N = 14;
  localparam int IFG_N = 24;
`ifdef MII_TX_FCS_EN
  localparam int MIN_P = 60;
`endif

  typedef struct packed {
    logic       underrun;
    logic       er;
    logic       done;
    logic [3:0] nib;
  } obs_t;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] mac_data;
  logic       mac_valid;
  logic       mac_last;
  logic       tx_mac_ready;
  logic       phy_tx_en;
  logic [3:0] phy_txd;
  logic       phy_tx_er;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  obs_t       exp_q[$];
  int         exp_len_q[$];
  logic [7:0] src_d[$];
  logic       src_l[$];

  int n_vec = 0;
  int n_err = 0;

  bit         in_frame = 1'b0;
  bit         had_er;
  int         gap = 1000;
  int         last_gap = 0;
  int         en_len;
  int         nib_idx;
  logic [3:0] lo_nib;
  logic [7:0] obs_bytes[$];
  obs_t       obs;
  obs_t       expv;
  int         len_exp;

  mii_tx_framer dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .tx_mac_data_i  (mac_data),
    .tx_mac_valid_i (mac_valid),
    .tx_mac_last_i  (mac_last),
    .tx_mac_ready_o (tx_mac_ready),
    .phy_tx_en_o    (phy_tx_en),
    .phy_txd_o      (phy_txd),
    .phy_tx_er_o    (phy_tx_er),
    .tx_busy_o      (tx_busy),
    .tx_done_o      (tx_done),
    .tx_underrun_o  (tx_underrun)
  );

  always #5 clk = ~clk;

`ifdef MII_TX_FCS_EN
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction
`endif

  // Queue a complete frame: source bytes plus the expected nibble stream and enable length
  task automatic add_frame(input byte_q_t fb);
    byte_q_t     pb;
    int          n;
    logic        done_hi;
    logic [31:0] c;
    n  = fb.size();
    pb = fb;
    for (int i = 0; i < PRE_N + 1; i++) exp_q.push_back({3'b000, 4'h5});
    exp_q.push_back({3'b000, 4'hD});
`ifdef MII_TX_FCS_EN
    while (pb.size() < MIN_P) pb.push_back(8'h00);
`endif
    for (int i = 0; i < pb.size(); i++) begin
`ifdef MII_TX_FCS_EN
      done_hi = 1'b0;
`else
      done_hi = (i == pb.size() - 1);
`endif
      exp_q.push_back({3'b000, pb[i][3:0]});
      exp_q.push_back({2'b00, done_hi, pb[i][7:4]});
    end
`ifdef MII_TX_FCS_EN
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < pb.size(); i++) c = model_crc(c, pb[i]);
    c = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back({2'b00, (k == 7), c[4*k +: 4]});
    exp_len_q.push_back(PRE_N + 2 + 2 * ((n > MIN_P) ? n : MIN_P) + 8);
`else
    exp_len_q.push_back(PRE_N + 2 + 2 * n);
`endif
    for (int i = 0; i < n; i++) begin
      src_d.push_back(fb[i]);
      src_l.push_back(i == n - 1);
    end
  endtask

  // Queue bytes that run dry before tx_mac_last: expect the two-cycle error tail
  task automatic add_underrun(input byte_q_t fb);
    for (int i = 0; i < PRE_N + 1; i++) exp_q.push_back({3'b000, 4'h5});
    exp_q.push_back({3'b000, 4'hD});
    for (int i = 0; i < fb.size(); i++) begin
      exp_q.push_back({3'b000, fb[i][3:0]});
      exp_q.push_back({3'b000, fb[i][7:4]});
      src_d.push_back(fb[i]);
      src_l.push_back(1'b0);
    end
    exp_q.push_back({3'b010, 4'h0});
    exp_q.push_back({3'b110, 4'h0});
    exp_len_q.push_back(PRE_N + 2 + 2 * fb.size() + 2);
  endtask

  // Present source bytes with valid held high; stop after stop_after accepted bytes (-1: all)
  task automatic stream(input int stop_after);
    int   acc;
    int   guard;
    logic rdy;
    acc   = 0;
    guard = 0;
    while (src_d.size() > 0 && acc != stop_after && guard < 5000) begin
      mac_valid = 1'b1;
      mac_data  = src_d[0];
      mac_last  = src_l[0];
      @(negedge clk);
      rdy = tx_mac_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        void'(src_d.pop_front());
        void'(src_l.pop_front());
        acc++;
      end
      guard++;
    end
    mac_valid = 1'b0;
    mac_last  = 1'b0;
    mac_data  = 8'h00;
    n_vec++;
    assert (guard < 5000) else begin
      n_err++;
      $error("FAIL stream_timeout accepted=%0d required=%0d", acc, stop_after);
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (i < 3000 && (exp_q.size() != 0 || tx_busy)) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    assert (i < 3000) else begin
      n_err++;
      $error("FAIL %s_idle_timeout pending=%0d busy=%b required=0/0", tag, exp_q.size(), tx_busy);
    end
    n_vec++;
    assert (exp_len_q.size() === 0) else begin
      n_err++;
      $error("FAIL %s_frames_missing pending=%0d required=0", tag, exp_len_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every enabled nibble, idle outputs, frame length and FCS residue
  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      gap      = 0;
    end else if (phy_tx_en) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        last_gap = gap;
        en_len   = 0;
        nib_idx  = 0;
        had_er   = 1'b0;
        obs_bytes.delete();
      end
      en_len++;
      obs = {tx_underrun, phy_tx_er, tx_done, phy_txd};
      if (phy_tx_er) had_er = 1'b1;
      if (nib_idx >= PRE_N + 2) begin
        if (((nib_idx - PRE_N - 2) % 2) == 0) lo_nib = phy_txd;
        else obs_bytes.push_back({phy_txd, lo_nib});
      end
      nib_idx++;
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL extra_nibble obs=%h required=none", obs);
      end
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        n_vec++;
        assert (obs === expv) else begin
          n_err++;
          $error("FAIL nibble[%0d] obs={ur,er,done,txd}=%h required=%h", nib_idx - 1, obs, expv);
        end
      end
      n_vec++;
      assert (tx_busy === 1'b1) else begin
        n_err++;
        $error("FAIL busy_in_frame obs=%b required=1", tx_busy);
      end
    end else begin
      n_vec++;
      assert ({tx_mac_ready, tx_done, tx_underrun, phy_tx_er, phy_txd} === 8'h00) else begin
        n_err++;
        $error("FAIL idle_outputs obs={rdy,done,ur,er,txd}=%b required=00000000",
               {tx_mac_ready, tx_done, tx_underrun, phy_tx_er, phy_txd});
      end
      if (in_frame) begin
        in_frame = 1'b0;
        gap      = 0;
        len_exp  = (exp_len_q.size() != 0) ? exp_len_q.pop_front() : -1;
        n_vec++;
        assert (en_len === len_exp) else begin
          n_err++;
          $error("FAIL frame_length obs=%0d required=%0d", en_len, len_exp);
        end
`ifdef MII_TX_FCS_EN
        if (!had_er) begin
          logic [31:0] res;
          res = 32'hFFFF_FFFF;
          foreach (obs_bytes[i]) res = model_crc(res, obs_bytes[i]);
          n_vec++;
          assert (res === 32'hDEBB20E3) else begin
            n_err++;
            $error("FAIL fcs_residue obs=%h required=debb20e3", res);
          end
        end
`endif
      end
      gap++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t f;
    reset_n   = 1'b0;
    mac_valid = 1'b0;
    mac_last  = 1'b0;
    mac_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    assert ({phy_tx_en, phy_txd, phy_tx_er, tx_mac_ready, tx_busy, tx_done, tx_underrun} === 10'h000) else begin
      n_err++;
      $error("FAIL reset_state obs=%b required=0000000000",
             {phy_tx_en, phy_txd, phy_tx_er, tx_mac_ready, tx_busy, tx_done, tx_underrun});
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 64-byte incrementing frame
    f.delete();
    for (int i = 0; i < 64; i++) f.push_back(8'(i));
    add_frame(f);
    stream(-1);
    wait_idle("frame64");

    // Single-byte runt frame
    f.delete();
    f.push_back(8'hAB);
    add_frame(f);
    stream(-1);
    wait_idle("frame1");

    // Two 60-byte frames back to back with valid held high
    for (int k = 0; k < 2; k++) begin
      f.delete();
      for (int i = 0; i < 60; i++) f.push_back(8'($urandom_range(0, 255)));
      add_frame(f);
    end
    stream(-1);
    wait_idle("b2b");
    n_vec++;
    assert (last_gap === IFG_N) else begin
      n_err++;
      $error("FAIL ifg_gap obs=%0d required=%0d", last_gap, IFG_N);
    end

    // Underrun: valid drops after byte 10 of a 20-byte frame
    f.delete();
    for (int i = 0; i < 10; i++) f.push_back(8'(8'h80 + i));
    add_underrun(f);
    stream(-1);
    wait_idle("underrun");

    // Reset during DATA of byte 30
    f.delete();
    for (int i = 0; i < 40; i++) f.push_back(8'($urandom_range(0, 255)));
    add_frame(f);
    stream(30);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    assert ({phy_tx_en, tx_busy, tx_mac_ready, phy_txd} === 7'h00) else begin
      n_err++;
      $error("FAIL reset_midframe obs={en,busy,rdy,txd}=%b required=0000000",
             {phy_tx_en, tx_busy, tx_mac_ready, phy_txd});
    end
    exp_q.delete();
    exp_len_q.delete();
    src_d.delete();
    src_l.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    f.delete();
    for (int i = 0; i < 12; i++) f.push_back(8'($urandom_range(0, 255)));
    add_frame(f);
    stream(-1);
    wait_idle("after_reset");

    // 10-byte frame
    f.delete();
    for (int i = 0; i < 10; i++) f.push_back(8'(8'hF0 + i));
    add_frame(f);
    stream(-1);
    wait_idle("frame10");

    // Long frame past the 7-bit byte counter range
    f.delete();
    for (int i = 0; i < 130; i++) f.push_back(8'($urandom_range(0, 255)));
    add_frame(f);
    stream(-1);
    wait_idle("frame130");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mii_tx_framer.md
Name: mii_tx_framer

Overview:
- MAC-side transmit framer for the 10/100 MII path.
- Takes a byte stream (tx_mac_data/valid/last) from the TX FIFO and drives phy_tx_en/phy_txd/phy_tx_er nibble-wise toward the PHY.
- Inserts preamble and SFD, zero-pads to minimum frame size, appends the CRC-32 FCS, then enforces the inter-frame gap.
- It is the transmit counterpart of the MII receive path feeding the MAC-to-FIFO top.

Parameters:
- MIN_PAYLOAD, 60, minimum bytes before FCS (DA+SA+type+data); shorter frames are zero-padded to this.
- PREAMBLE_NIBBLES, 14, count of 0x5 nibbles before the SFD.
- IFG_CYCLES, 24, minimum clk cycles with phy_tx_en low between frames (96 bit times).

Ports:
- clk  in  1  MII transmit clock (phy_tx_clk rate); all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- tx_mac_data  in  8  frame byte from FIFO.
- tx_mac_valid  in  1  tx_mac_data valid.
- tx_mac_last  in  1  marks final byte of frame; qualified by valid.
- tx_mac_ready  out  1  byte accepted at this edge when valid&ready.
- phy_tx_en  out  1  MII TX_EN.
- phy_txd  out  4  MII TXD nibble.
- phy_tx_er  out  1  MII TX_ER; asserted only on underrun.
- tx_busy  out  1  high from leaving IDLE until IFG complete.
- tx_done  out  1  one-cycle pulse on the last FCS nibble (or last data nibble without FCS).
- tx_underrun  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; all outputs 0; CRC = 0xFFFFFFFF; counters cleared.
- Reset mid-frame: phy_tx_en drops at the next edge, with no tail and no IFG enforced.
- States: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
- IDLE: on tx_mac_valid=1, go to PRE. phy_tx_en=1 and txd=0x5 from the next cycle; tx_mac_ready=0.
- PRE: emit PREAMBLE_NIBBLES cycles of 0x5.
- SFD: emit 0x5 then 0xD, low nibble first. tx_mac_ready=1 in the 0xD cycle, which accepts the first byte.
- DATA, nibble order: each accepted byte is registered; its low nibble goes out in the next cycle, its high nibble in the cycle after.
- DATA, readiness: tx_mac_ready=1 only in high-nibble cycles, so one byte is accepted per 2 clk.
- DATA, CRC: updates over every transmitted data byte.
- Underrun: valid=0 when ready=1 mid-frame aborts the frame.
  - Emit 2 cycles of phy_tx_en=1, phy_tx_er=1, txd=0.
  - Pulse tx_underrun, then go to IFG.
  - The FIFO must discard the remainder up to and including tx_mac_last.
- Last byte: when the accepted byte carries tx_mac_last, go to PAD if byte count < MIN_PAYLOAD, else to FCS.
- Byte counter: 7 bits, saturating at MIN_PAYLOAD; it does not wrap on long frames.
- PAD: emit 0x00 bytes (2 nibbles each, included in CRC) until count = MIN_PAYLOAD.
- FCS: emit ~CRC as 8 nibbles, LSB nibble first. Bits within each nibble follow reflected order (crc[3:0] first).
- CRC definition: reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
- FCS end: pulse tx_done on the 8th nibble; phy_tx_en=0 from the next cycle.
- IFG: phy_tx_en=0 for IFG_CYCLES cycles while ignoring valid; then IDLE.
- Back-to-back frames: a frame waiting with valid=1 starts its preamble on the cycle after IFG completes.
- Frame length: phy_tx_en high for exactly PREAMBLE_NIBBLES + 2 + 2*max(N, MIN_PAYLOAD) + 8 cycles for an N-byte frame.
- Frame boundary: tx_mac_last is observed only on accepted bytes; tx_mac_last without valid is ignored.
- Idle outputs: phy_txd=0 whenever phy_tx_en=0.

Optional Feature:
- Macro MII_TX_FCS_EN.
- Defined:
  - PAD and FCS states are present, as described in Behaviour.
- Undefined:
  - PAD and FCS are removed; no CRC logic is built.
  - The frame ends after the last data byte's high nibble; tx_done pulses on that nibble.
  - Upstream supplies any padding and FCS, and runt frames are transmitted as given.
  - Minimum enable time is PREAMBLE_NIBBLES + 2 + 2N.

Test Plan:
- Reset, then 64-byte frame (0x00..0x3F, FCS_EN): phy_tx_en high 14+2+128+8 = 152 cycles; nibbles 5×15, D, then 0,0,1,0,2,0...; bench CRC over data+FCS (no final invert) yields residue 0xDEBB20E3; tx_done on cycle 152.
- 1-byte frame 0xAB with last=1: payload AB followed by 59 zero bytes; enable 14+2+120+8 = 144 cycles; FCS matches bench model of 60-byte padded frame.
- Two 60-byte frames with valid held high: first cycle of phy_tx_en=0 followed by exactly 24 low cycles, then 0x5 on the 25th; tx_mac_ready low throughout IFG.
- Underrun: 20-byte stream with valid dropped after byte 10 → 2 cycles phy_tx_er=1/txd=0, tx_underrun pulse, phy_tx_en=0 next cycle, no FCS, tx_done never pulses.
- reset=0 asserted during DATA of byte 30 → phy_tx_en=0 and tx_busy=0 at next edge; new frame after release starts cleanly and carries a correct FCS.
- MII_TX_FCS_EN undefined, 10-byte frame: enable 36 cycles, last nibble is byte 9 high nibble, tx_done on that cycle, no padding.
